// File: rtl/fetch_unit.sv
// Instruction fetch stage: produces next-PC, issues single-outstanding imem reads
// and buffers returned words as {pc, inst} pairs for decode.
module fetch_unit #(
  parameter int          DEPTH       = 2,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [1:0]  fsm_state
);
  // Handshakes: imem_req stays high with a stable imem_addr until a cycle with
  // imem_ack, which completes it; a decode transfer happens in any cycle where
  // inst_valid and inst_ready are both high, and inst_valid never depends on inst_ready.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [31:0]   addr_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic          push;
  logic          pop;
  logic          room;

  assign push       = (state == WAIT) & imem_ack & ~redirect;
  assign inst_valid = (count != '0) & ~redirect;
  assign pop        = inst_valid & inst_ready;
  assign count_nxt  = count + CW'(push) - CW'(pop);
  assign room       = (count_nxt < FULL);

  assign imem_req  = (state != IDLE);
  assign inst_data = inst_mem[rd_ptr];
  assign inst_pc   = pc_mem[rd_ptr];
  assign fsm_state = state;

  // The PC register has no enable: hold it unless a live fetch completes.
  always_comb begin
    pc_next = pc_cur;
    if (redirect) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if ((state == WAIT) && imem_ack) begin
      pc_next = imem_addr + 32'd4;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = imem_addr;
    case (state)
      IDLE: begin
        if (!redirect && room) begin
          state_nxt = WAIT;
          addr_nxt  = pc_cur;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_nxt = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          if (room) begin
            addr_nxt = imem_addr + 32'd4;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        // The stale request is never withdrawn; its data is thrown away.
        if (imem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      imem_addr <= RESET_VALUE;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      imem_addr <= addr_nxt;
      if (redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count_nxt;
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  // Queue storage needs no reset; entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= imem_addr;
      inst_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a stream model of the instructions decode should receive.
module tb_fetch_unit;
  localparam int          DEPTH       = 2;
  localparam logic [31:0] RESET_VALUE = 32'h0000_0000;
  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_WAIT      = 2'd1;
  localparam logic [1:0]  S_DROP      = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic [1:0]  fsm_state;

  int errors = 0;
  int checks = 0;

  // memory model controls
  bit          mem_auto = 1'b0;
  bit          mem_rand = 1'b0;
  int          mem_lat = 0;
  int          cur_lat = 0;
  int          wait_cnt = 0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_rdata = '0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;

  logic [63:0] exp_q[$];

  assign imem_ack   = mem_auto ? auto_ack : man_ack;
  assign imem_rdata = mem_auto ? auto_rdata : man_rdata;

  fetch_unit #(.DEPTH(DEPTH), .RESET_VALUE(RESET_VALUE)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .fsm_state(fsm_state)
  );

  // clock / reset block, plus the PC register the fetch unit sits around
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) pc_cur <= RESET_VALUE;
    else     pc_cur <= pc_next;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // instruction memory: acks after cur_lat stall cycles of a held request
  always @(negedge clk) begin
    if (rst || !imem_req) begin
      auto_ack = 1'b0;
      wait_cnt = 0;
      cur_lat  = mem_lat;
    end else if (wait_cnt >= cur_lat) begin
      auto_ack   = 1'b1;
      auto_rdata = mem_word(imem_addr);
      wait_cnt   = 0;
      cur_lat    = mem_rand ? int'($urandom_range(0, 2)) : mem_lat;
    end else begin
      auto_ack = 1'b0;
      wait_cnt++;
    end
  end

  // driver tasks
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; man_ack = 1'b0; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    mem_auto = 1'b0; man_ack = 1'b0; inst_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    checks++; if (imem_addr !== RESET_VALUE) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_VALUE); end
    checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", fsm_state, S_IDLE); end
    checks++; if (pc_next !== RESET_VALUE) begin errors++; $display("FAIL reset_pc_next: got %h want %h", pc_next, RESET_VALUE); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_release_req: got %b want 0", imem_req); end
    cyc();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_VALUE) begin errors++; $display("FAIL reset_first_req: got req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_VALUE); end
    checks++; if (fsm_state !== S_WAIT) begin errors++; $display("FAIL reset_first_state: got %0d want %0d", fsm_state, S_WAIT); end
    inst_ready = 1'b0;
  endtask

  task automatic test_fetch();
    logic [31:0] a;
    mem_auto = 1'b1; mem_rand = 1'b0; mem_lat = 0;
    do_reset();
    inst_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fetch_idle_req: got %b want 0", imem_req); end
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      a = 32'(4 * i);
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("FAIL fetch_addr[%0d]: got req=%b addr=%h want 1 %h", i, imem_req, imem_addr, a); end
      checks++; if (pc_next !== pc_cur + 32'd4 || pc_next !== a + 32'd4) begin errors++; $display("FAIL fetch_pc_next[%0d]: got %h (pc_cur %h) want %h", i, pc_next, pc_cur, a + 32'd4); end
      if (i == 0) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_latency: got valid=%b want 0", inst_valid); end
      end else begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== a - 32'd4 || inst_data !== mem_word(a - 32'd4)) begin
          errors++; $display("FAIL fetch_inst[%0d]: got v=%b pc=%h d=%h want 1 %h %h", i, inst_valid, inst_pc, inst_data, a - 32'd4, mem_word(a - 32'd4));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int pushes;
    mem_auto = 1'b1; mem_rand = 1'b0; mem_lat = 0;
    do_reset();
    inst_ready = 1'b0;
    pushes = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      if (imem_req && imem_ack) pushes++;
    end
    checks++; if (pushes != DEPTH) begin errors++; $display("FAIL bp_pushes: got %0d want %0d", pushes, DEPTH); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_drop: got %b want 0", imem_req); end
    checks++; if (pc_next !== pc_cur || pc_cur !== 32'h8) begin errors++; $display("FAIL bp_pc_hold: got next=%h cur=%h want 8 8", pc_next, pc_cur); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h want 1 0", inst_valid, inst_pc); end
    inst_ready = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== mem_word(32'h0)) begin errors++; $display("FAIL bp_drain0: got v=%b pc=%h d=%h want 1 0 %h", inst_valid, inst_pc, inst_data, mem_word(32'h0)); end
    cyc(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== mem_word(32'h4)) begin errors++; $display("FAIL bp_drain4: got v=%b pc=%h d=%h want 1 4 %h", inst_valid, inst_pc, inst_data, mem_word(32'h4)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL bp_resume: got req=%b addr=%h want 1 8", imem_req, imem_addr); end
    cyc(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8) begin errors++; $display("FAIL bp_next: got v=%b pc=%h want 1 8", inst_valid, inst_pc); end
  endtask

  task automatic test_slow_mem();
    logic [31:0] exp_addr;
    logic [31:0] pend_pc;
    bit pend;
    int stall;
    int acks;
    mem_auto = 1'b1; mem_rand = 1'b0; mem_lat = 3;
    do_reset();
    inst_ready = 1'b1;
    exp_addr = 32'h0; pend = 1'b0; pend_pc = '0; stall = 0; acks = 0;
    for (int i = 0; i < 30 && acks < 3; i++) begin
      cyc(); #1;
      if (pend) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== pend_pc || inst_data !== mem_word(pend_pc)) begin
          errors++; $display("FAIL slow_push: got v=%b pc=%h d=%h want 1 %h %h", inst_valid, inst_pc, inst_data, pend_pc, mem_word(pend_pc));
        end
        pend = 1'b0;
      end
      if (imem_req) begin
        checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL slow_addr: got %h want %h", imem_addr, exp_addr); end
        if (imem_ack) begin
          checks++; if (stall != 3) begin errors++; $display("FAIL slow_stall: got %0d want 3", stall); end
          pend = 1'b1; pend_pc = exp_addr; exp_addr += 32'd4; stall = 0; acks++;
        end else begin
          stall++;
        end
      end
    end
    checks++; if (acks != 3) begin errors++; $display("FAIL slow_timeout: got %0d acks want 3", acks); end
    cyc(); #1;
    checks++; if (pend && (inst_valid !== 1'b1 || inst_pc !== pend_pc)) begin errors++; $display("FAIL slow_last: got v=%b pc=%h want 1 %h", inst_valid, inst_pc, pend_pc); end
  endtask

  task automatic test_redirect_wait();
    mem_auto = 1'b0;
    do_reset();
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h10; #1;
    checks++; if (pc_next !== 32'h10 || imem_req !== 1'b0) begin errors++; $display("FAIL rw_idle_redirect: got next=%h req=%b want 10 0", pc_next, imem_req); end
    cyc(); redirect = 1'b0; #1;
    cyc(); #1;
    checks++; if (fsm_state !== S_WAIT || imem_addr !== 32'h10 || imem_req !== 1'b1) begin errors++; $display("FAIL rw_wait: got st=%0d addr=%h req=%b want 1 10 1", fsm_state, imem_addr, imem_req); end
    cyc(); redirect = 1'b1; redirect_pc = 32'h200; #1;
    checks++; if (pc_next !== 32'h200 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_redirect: got next=%h v=%b want 200 0", pc_next, inst_valid); end
    cyc(); redirect = 1'b0; #1;
    checks++; if (fsm_state !== S_DROP || imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL rw_drop: got st=%0d req=%b addr=%h want 2 1 10", fsm_state, imem_req, imem_addr); end
    checks++; if (inst_valid !== 1'b0 || pc_cur !== 32'h200) begin errors++; $display("FAIL rw_flush: got v=%b pc=%h want 0 200", inst_valid, pc_cur); end
    cyc(); #1;
    checks++; if (fsm_state !== S_DROP) begin errors++; $display("FAIL rw_drop_hold: got %0d want 2", fsm_state); end
    man_ack = 1'b1; man_rdata = 32'hDEAD_0010; #1;
    checks++; if (pc_next !== 32'h200) begin errors++; $display("FAIL rw_drop_ack_pc: got %h want 200", pc_next); end
    cyc(); man_ack = 1'b0; #1;
    checks++; if (fsm_state !== S_IDLE || inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rw_idle: got st=%0d v=%b req=%b want 0 0 0", fsm_state, inst_valid, imem_req); end
    cyc(); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_new_req: got req=%b addr=%h v=%b want 1 200 0", imem_req, imem_addr, inst_valid); end
    man_ack = 1'b1; man_rdata = mem_word(32'h200); #1;
    checks++; if (pc_next !== 32'h204) begin errors++; $display("FAIL rw_new_pc: got %h want 204", pc_next); end
    cyc(); man_ack = 1'b0; #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst_data !== mem_word(32'h200)) begin errors++; $display("FAIL rw_new_inst: got v=%b pc=%h d=%h want 1 200 %h", inst_valid, inst_pc, inst_data, mem_word(32'h200)); end
  endtask

  task automatic test_redirect_ack_wrap();
    mem_auto = 1'b0;
    do_reset();
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h40; #1;
    cyc(); redirect = 1'b0; #1;
    cyc(); man_ack = 1'b1; man_rdata = mem_word(32'h40); #1;
    checks++; if (imem_addr !== 32'h40 || pc_next !== 32'h44) begin errors++; $display("FAIL ra_first: got addr=%h next=%h want 40 44", imem_addr, pc_next); end
    cyc(); man_rdata = 32'hBAD0_0044; redirect = 1'b1; redirect_pc = 32'h203; #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ra_valid_masked: got %b want 0", inst_valid); end
    checks++; if (pc_next !== 32'h200) begin errors++; $display("FAIL ra_align: got %h want 200", pc_next); end
    cyc(); man_ack = 1'b0; redirect = 1'b0; #1;
    checks++; if (fsm_state !== S_IDLE || inst_valid !== 1'b0 || pc_cur !== 32'h200) begin errors++; $display("FAIL ra_discard: got st=%0d v=%b pc=%h want 0 0 200", fsm_state, inst_valid, pc_cur); end
    cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF9; #1;
    checks++; if (pc_next !== 32'hFFFF_FFF8) begin errors++; $display("FAIL ra_redirect2: got %h want fffffff8", pc_next); end
    cyc(); redirect = 1'b0; #1;
    checks++; if (fsm_state !== S_DROP) begin errors++; $display("FAIL ra_drop: got %0d want 2", fsm_state); end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
    checks++; if (pc_next !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ra_drop_redirect: got %h want fffffffc", pc_next); end
    cyc(); redirect = 1'b0; #1;
    checks++; if (fsm_state !== S_DROP || pc_cur !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ra_drop_stay: got st=%0d pc=%h want 2 fffffffc", fsm_state, pc_cur); end
    man_ack = 1'b1; man_rdata = 32'hBAD0_0200; #1;
    cyc(); man_ack = 1'b0; #1;
    cyc(); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ra_wrap_req: got req=%b addr=%h want 1 fffffffc", imem_req, imem_addr); end
    man_ack = 1'b1; man_rdata = mem_word(32'hFFFF_FFFC); #1;
    checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL ra_wrap_pc: got %h want 0", pc_next); end
    cyc(); man_ack = 1'b0; #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL ra_wrap_inst: got v=%b pc=%h d=%h want 1 fffffffc %h", inst_valid, inst_pc, inst_data, mem_word(32'hFFFF_FFFC)); end
    checks++; if (imem_addr !== 32'h0 || pc_cur !== 32'h0) begin errors++; $display("FAIL ra_wrap_addr: got addr=%h pc=%h want 0 0", imem_addr, pc_cur); end
  endtask

  task automatic test_async_reset();
    bit found;
    mem_auto = 1'b1; mem_rand = 1'b0; mem_lat = 2;
    do_reset();
    inst_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cyc(); #1;
      if (inst_valid && imem_req && !imem_ack) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL ar_setup: got no WAIT with 1 entry want found"); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL ar_async: got req=%b v=%b want 0 0", imem_req, inst_valid); end
    checks++; if (fsm_state !== S_IDLE || imem_addr !== RESET_VALUE) begin errors++; $display("FAIL ar_state: got st=%0d addr=%h want 0 %h", fsm_state, imem_addr, RESET_VALUE); end
  endtask

  task automatic test_random();
    logic [31:0] model_pc;
    logic [31:0] tgt;
    logic [63:0] exp_e;
    int accepted;
    mem_auto = 1'b1; mem_rand = 1'b1; mem_lat = 0;
    do_reset();
    model_pc = RESET_VALUE; accepted = 0;
    exp_q.delete();
    for (int i = 0; i < 800; i++) begin
      cyc();
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      #1;
      if (redirect) begin
        tgt = {redirect_pc[31:2], 2'b00};
        checks++; if (inst_valid !== 1'b0 || pc_next !== tgt) begin errors++; $display("FAIL rnd_redirect[%0d]: got v=%b next=%h want 0 %h", i, inst_valid, pc_next, tgt); end
        exp_q.delete();
        model_pc = tgt;
      end else begin
        if (!(imem_req && imem_ack)) begin
          checks++; if (pc_next !== pc_cur) begin errors++; $display("FAIL rnd_pc_hold[%0d]: got %h want %h", i, pc_next, pc_cur); end
        end
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back({model_pc, mem_word(model_pc)});
            model_pc += 32'd4;
          end
          exp_e = exp_q.pop_front();
          accepted++;
          checks++; if ({inst_pc, inst_data} !== exp_e) begin errors++; $display("FAIL rnd_inst[%0d]: got pc=%h d=%h want %h %h", i, inst_pc, inst_data, exp_e[63:32], exp_e[31:0]); end
        end
      end
    end
    redirect = 1'b0; mem_rand = 1'b0;
    checks++; if (accepted < 50) begin errors++; $display("FAIL rnd_progress: got %0d accepted want >= 50", accepted); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_slow_mem();
    test_redirect_wait();
    test_redirect_ack_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits around the PC register.
- Consumes the current PC and generates the next-PC value written back into the PC register every clock.
- Issues one-outstanding-request reads to instruction memory with a req/ack handshake and buffers the returned words in a small queue.
- Presents {pc, instruction} pairs to decode with a valid/ready handshake, and handles branch/jump redirects by flushing and discarding in-flight fetches.

Parameters:
- DEPTH, 2, instruction queue entries (power of two, ≥2).
- RESET_VALUE, 32'h0000_0000, reset value of the request-address register; matches the PC reset value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_cur  input  32  current PC, driven by the PC register output.
- pc_next  output  32  next PC, drives the PC register input (combinational).
- redirect  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  redirect target.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  read address (registered).
- imem_ack  input  1  read data valid; completes the request.
- imem_rdata  input  32  instruction word.
- inst_valid  output  1  queue head valid to decode.
- inst_data  output  32  head instruction.
- inst_pc  output  32  PC of the head instruction.
- inst_ready  input  1  decode accepts the head.

Behaviour:
- Clock and reset: one clock domain; the asynchronous reset forces:
  - state IDLE
  - queue count 0
  - imem_req 0
  - imem_addr RESET_VALUE
  - inst_valid 0
- PC is held, not enabled: the PC register has no enable, so pc_next = pc_cur whenever no fetch completes. pc_next priority:
  - redirect: {redirect_pc[31:2], 2'b00}
  - else WAIT state with imem_ack: imem_addr + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0)
  - else pc_cur
- Invariant: count + outstanding ≤ DEPTH, so a push never overflows the queue.
- count_nxt = count + push − pop, where push = WAIT & imem_ack & !redirect and pop = inst_valid & inst_ready.
- State IDLE:
  - imem_req = 0.
  - If !redirect and count_nxt < DEPTH: imem_addr <= pc_cur, go to WAIT (imem_req high from the next cycle).
- State WAIT:
  - imem_req = 1; imem_addr stays stable until ack.
  - imem_ack & !redirect: push {imem_addr, imem_rdata}.
    - If count_nxt < DEPTH: stay in WAIT with imem_addr <= imem_addr + 4 (back-to-back, one instruction per cycle).
    - Otherwise go to IDLE.
  - imem_ack & redirect: discard the data, go to IDLE.
  - !imem_ack & redirect: go to DROP.
- State DROP:
  - imem_req = 1, imem_addr unchanged (the old request is never withdrawn).
  - On imem_ack, discard the data and go to IDLE.
  - A redirect while in DROP updates pc_next only; the state stays DROP.
- Queue: FIFO of DEPTH entries, each {pc, inst}.
  - inst_valid = (count != 0) & !redirect; inst_data/inst_pc come from the head entry.
  - Pop when inst_valid & inst_ready; a push and a pop in the same cycle are allowed at any count.
- Redirect flush: the queue is emptied at the next edge. A pop in the redirect cycle is suppressed because inst_valid is forced to 0.
- Reset mid-request: the request is dropped immediately. The memory side must tolerate the withdrawn request, as all memories on our bus do.
- Latency: pc_cur to its first inst_valid is at least 2 cycles (issue edge, then ack cycle, then visible next cycle); sustained throughput is 1 per cycle with single-cycle ack and inst_ready held high.

Test Plan:
- Reset then fetch: PC reset to 0, imem_ack always 1, inst_ready 1.
  - imem_addr sequence is 0, 4, 8, 12 on consecutive cycles.
  - inst_pc is 0, 4, 8 with matching data.
  - pc_next = pc_cur + 4 on every ack.
- Backpressure: hold inst_ready = 0.
  - Exactly 2 entries are pushed, imem_req then drops, and pc_next = pc_cur holds.
  - After ready returns, 0x0 and 0x4 drain in order and fetch resumes at 0x8.
- Slow memory: ack 3 cycles after req.
  - imem_addr and imem_req stay stable for all 3 cycles.
  - One entry is pushed per ack.
- Redirect while waiting: WAIT at address 0x10 without ack, redirect_pc = 0x200.
  - pc_next = 0x200 and the queue is empty the next cycle.
  - The state holds DROP until ack; the 0x10 data is never presented.
  - The next request uses address 0x200.
- Redirect with simultaneous ack, plus wrap-around:
  - The acked word is discarded and inst_valid is 0 in the redirect cycle.
  - redirect_pc = 0x203 yields pc_next = 0x200.
  - A fetch at 0xFFFF_FFFC yields pc_next = 0.
- Async reset asserted mid-WAIT with the queue holding 1 entry: imem_req and inst_valid go to 0 immediately without waiting for a clock edge, and the state returns to IDLE.
